vector_execute_stage: RTL and testbench

Execute stage of the Filter-GPU pipeline, directly downstream of the decode/execute register buffer. Consumes the buffered 3-lane operands, immediate and control bits, runs the 3-lane ALU, and registers results plus pass-through control into the execute/memory boundary. Fixed-point multiply shares one multiplier across lanes over three cycles. While it runs, the stage raises `stall` so the upstream buffer holds its contents.

---
 rtl/vector_execute_stage_pkg.sv | 52 +++++
 rtl/vector_execute_stage_if.sv | 59 +++++
 rtl/vector_execute_stage_lane.sv | 78 +++++++
 rtl/vector_execute_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_vector_execute_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared types and constants for the Filter-GPU execute stage.
//   N, FRAC, LANES   lane width, fixed-point fraction bits, lane count
//   FLAG_*           bit positions inside the {N,Z,C,V} flags word
//   lane_t           one signed lane value
//   alu_op_t         ALUControl encodings (12..15 are unused and yield 0)
//   state_t          execute-stage FSM states
//   SAT_MAX/SAT_MIN  saturation bounds shared by MUL, ADDS and SUBS
// ---------------------------------------------------------------------------
package gpu_pkg;

    localparam int N     = 18;
    localparam int FRAC  = 8;
    localparam int LANES = 3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic signed [N-1:0] lane_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_MUL   = 4'd7,
        OP_ADDS  = 4'd8,
        OP_SUBS  = 4'd9,
        OP_PASSB = 4'd10,
        OP_AVG   = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        MUL2 = 2'd3
    } state_t;

    localparam lane_t SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam lane_t SAT_MIN = {1'b1, {(N-1){1'b0}}};

    // Shift amounts at or above the lane width flush the lane to zero.
    localparam logic [4:0] SHAMT_LIMIT = 5'(N);

endpackage

// File: rtl/vector_execute_stage_if.sv
// ---------------------------------------------------------------------------
// vector_execute_stage_if
// Bundles the decode/execute-buffer side and the execute/memory side of the
// execute stage.
//   master : upstream/downstream environment (drives instruction, sees results)
//   slave  : the execute stage itself
// Handshake: the stage accepts the instruction presented with valid_i on a
// rising edge only while stall is low; while stall is high the upstream holds
// every input steady. valid_o marks one completed instruction per cycle it is
// high; the downstream has no back-pressure. flush kills the current input and
// any in-flight multiply on the edge where it is sampled.
// ---------------------------------------------------------------------------
interface vector_execute_stage_if;
    import gpu_pkg::*;

    // decode/execute side
    logic               valid_i;
    lane_t [LANES-1:0]  rd1;
    lane_t [LANES-1:0]  rd2;
    lane_t [LANES-1:0]  extend;
    logic               ALUSrc;
    logic [3:0]         ALUControl;
    logic               FlagWrite;
    logic               RegWrite;
    logic               MemtoReg;
    logic               MemWrite;
    logic               Branch;
    logic               PCSrc;
    logic [3:0]         WA3;
    logic               flush;
    logic               stall;

    // execute/memory side
    logic               valid_o;
    lane_t [LANES-1:0]  alu_result;
    lane_t [LANES-1:0]  write_data;
    logic [3:0]         flags;
    logic               RegWriteO;
    logic               MemtoRegO;
    logic               MemWriteO;
    logic               BranchO;
    logic               PCSrcO;
    logic [3:0]         WA3O;

    modport master (
        output valid_i, rd1, rd2, extend, ALUSrc, ALUControl, FlagWrite,
               RegWrite, MemtoReg, MemWrite, Branch, PCSrc, WA3, flush,
        input  stall, valid_o, alu_result, write_data, flags, RegWriteO,
               MemtoRegO, MemWriteO, BranchO, PCSrcO, WA3O
    );

    modport slave (
        input  valid_i, rd1, rd2, extend, ALUSrc, ALUControl, FlagWrite,
               RegWrite, MemtoReg, MemWrite, Branch, PCSrc, WA3, flush,
        output stall, valid_o, alu_result, write_data, flags, RegWriteO,
               MemtoRegO, MemWriteO, BranchO, PCSrcO, WA3O
    );

endinterface

// File: rtl/vector_execute_stage_lane.sv
// ---------------------------------------------------------------------------
// vector_alu_lane
// Combinational single-lane ALU covering every operation except MUL, plus the
// {N,Z,C,V} flags for that lane.
//   i_a, i_b   lane operands (B already muxed between rd2 and extend)
//   i_op       ALUControl code; MUL and codes 12..15 give 0
//   o_result   lane result
//   o_flags    {N,Z,C,V}
// ---------------------------------------------------------------------------
module vector_alu_lane import gpu_pkg::*; (
    input  lane_t       i_a,
    input  lane_t       i_b,
    input  logic [3:0]  i_op,
    output lane_t       o_result,
    output logic [3:0]  o_flags
);

    // Unsigned N+1 forms give carry / borrow; sign-extended forms give
    // overflow detection, the saturated sums and the N+1-bit average.
    logic [N:0] w_uadd;
    logic [N:0] w_usub;
    logic [N:0] w_sadd;
    logic [N:0] w_ssub;
    logic       w_add_ov;
    logic       w_sub_ov;
    logic [4:0] w_shamt;
    logic       w_shift_zero;
    lane_t      w_res;

    assign w_uadd       = {1'b0, i_a} + {1'b0, i_b};
    assign w_usub       = {1'b0, i_a} - {1'b0, i_b};
    assign w_sadd       = {i_a[N-1], i_a} + {i_b[N-1], i_b};
    assign w_ssub       = {i_a[N-1], i_a} - {i_b[N-1], i_b};
    assign w_add_ov     = (w_sadd[N] != w_sadd[N-1]);
    assign w_sub_ov     = (w_ssub[N] != w_ssub[N-1]);
    assign w_shamt      = i_b[4:0];
    assign w_shift_zero = (w_shamt >= SHAMT_LIMIT);

    always_comb begin
        w_res   = '0;
        o_flags = '0;
        case (i_op)
            OP_ADD:   w_res = w_uadd[N-1:0];
            OP_SUB:   w_res = w_usub[N-1:0];
            OP_AND:   w_res = i_a & i_b;
            OP_OR:    w_res = i_a | i_b;
            OP_XOR:   w_res = i_a ^ i_b;
            OP_SHL:   w_res = w_shift_zero ? '0 : (i_a << w_shamt);
            OP_SHR:   w_res = w_shift_zero ? '0 : (i_a >> w_shamt);
            // On overflow the true sign is the extended MSB.
            OP_ADDS:  w_res = w_add_ov ? (w_sadd[N] ? SAT_MIN : SAT_MAX) : w_sadd[N-1:0];
            OP_SUBS:  w_res = w_sub_ov ? (w_ssub[N] ? SAT_MIN : SAT_MAX) : w_ssub[N-1:0];
            OP_PASSB: w_res = i_b;
            OP_AVG:   w_res = w_sadd[N:1];
            default:  w_res = '0;
        endcase

        o_flags[FLAG_N] = w_res[N-1];
        o_flags[FLAG_Z] = (w_res == '0);
        case (i_op)
            OP_ADD, OP_ADDS: begin
                o_flags[FLAG_C] = w_uadd[N];
                o_flags[FLAG_V] = w_add_ov;
            end
            OP_SUB, OP_SUBS: begin
                o_flags[FLAG_C] = ~w_usub[N];
                o_flags[FLAG_V] = w_sub_ov;
            end
            default: begin
                o_flags[FLAG_C] = 1'b0;
                o_flags[FLAG_V] = 1'b0;
            end
        endcase
    end

    assign o_result = w_res;

endmodule

// File: rtl/vector_execute_stage.sv
// ---------------------------------------------------------------------------
// vector_execute_stage
// Execute stage: three-lane ALU for single-cycle ops and one shared
// fixed-point multiplier walked across the lanes over MUL0..MUL2.
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   bus          slave side of vector_execute_stage_if
//   o_dbg_state  current FSM state
// ---------------------------------------------------------------------------
module vector_execute_stage import gpu_pkg::*; (
    input  logic                  clk,
    input  logic                  reset,
    vector_execute_stage_if.slave bus,
    output state_t                o_dbg_state
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_is_mul;
    logic w_fire_alu;
    logic w_fire_mul;
    logic w_mul_done;

    lane_t [LANES-1:0]      w_opb;
    lane_t [LANES-1:0]      w_lane_res;
    logic  [LANES-1:0][3:0] w_lane_flags;

    // Instruction captured at MUL accept; upstream holds too, but the copy
    // keeps the multiply independent of what the buffer shows afterwards.
    lane_t [LANES-1:0] r_mul_a;
    lane_t [LANES-1:0] r_mul_b;
    lane_t [LANES-1:0] r_mul_rd2;
    logic              r_mul_fw;
    logic              r_mul_rw;
    logic              r_mul_m2r;
    logic              r_mul_mw;
    logic              r_mul_br;
    logic              r_mul_pcs;
    logic [3:0]        r_mul_wa3;
    lane_t             r_mul_res0;
    lane_t             r_mul_res1;
    logic              r_mul_v0;

    lane_t                 w_ma;
    lane_t                 w_mb;
    logic signed [2*N-1:0] w_prod;
    logic signed [2*N-1:0] w_shift;
    logic                  w_mul_ovf;
    lane_t                 w_mul_sat;
    logic [3:0]            w_mul_flags;

    logic              r_valid_o;
    lane_t [LANES-1:0] r_result;
    lane_t [LANES-1:0] r_wdata;
    logic [3:0]        r_flags;
    logic              r_rw;
    logic              r_m2r;
    logic              r_mw;
    logic              r_br;
    logic              r_pcs;
    logic [3:0]        r_wa3;

    // ---------------- lane ALUs ----------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_opb[g] = bus.ALUSrc ? bus.extend[g] : bus.rd2[g];
        vector_alu_lane u_lane (
            .i_a      (bus.rd1[g]),
            .i_b      (w_opb[g]),
            .i_op     (bus.ALUControl),
            .o_result (w_lane_res[g]),
            .o_flags  (w_lane_flags[g])
        );
    end

    assign w_is_mul = (bus.ALUControl == OP_MUL);

    // ---------------- shared multiplier ----------------
    always_comb begin
        w_ma = r_mul_a[2];
        w_mb = r_mul_b[2];
        case (r_state)
            MUL0: begin
                w_ma = r_mul_a[0];
                w_mb = r_mul_b[0];
            end
            MUL1: begin
                w_ma = r_mul_a[1];
                w_mb = r_mul_b[1];
            end
            default: ;
        endcase
    end

    assign w_prod  = w_ma * w_mb;
    assign w_shift = w_prod >>> FRAC;
    // In range only if every bit from the lane MSB upwards matches.
    assign w_mul_ovf = !((&w_shift[2*N-1:N-1]) || !(|w_shift[2*N-1:N-1]));
    assign w_mul_sat = w_mul_ovf ? (w_shift[2*N-1] ? SAT_MIN : SAT_MAX) : w_shift[N-1:0];

    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = r_mul_res0[N-1];
        w_mul_flags[FLAG_Z] = (r_mul_res0 == '0);
        w_mul_flags[FLAG_V] = r_mul_v0;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire_alu  = 1'b0;
        w_fire_mul  = 1'b0;
        w_mul_done  = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        if (w_is_mul) begin
                            w_fire_mul  = 1'b1;
                            w_state_nxt = MUL0;
                        end else begin
                            w_fire_alu  = 1'b1;
                        end
                    end
                end
                MUL0: w_state_nxt = MUL1;
                MUL1: w_state_nxt = MUL2;
                MUL2: begin
                    w_mul_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_rd2  <= '0;
            r_mul_fw   <= 1'b0;
            r_mul_rw   <= 1'b0;
            r_mul_m2r  <= 1'b0;
            r_mul_mw   <= 1'b0;
            r_mul_br   <= 1'b0;
            r_mul_pcs  <= 1'b0;
            r_mul_wa3  <= '0;
            r_mul_res0 <= '0;
            r_mul_res1 <= '0;
            r_mul_v0   <= 1'b0;
            r_valid_o  <= 1'b0;
            r_result   <= '0;
            r_wdata    <= '0;
            r_flags    <= '0;
            r_rw       <= 1'b0;
            r_m2r      <= 1'b0;
            r_mw       <= 1'b0;
            r_br       <= 1'b0;
            r_pcs      <= 1'b0;
            r_wa3      <= '0;
        end else begin
            r_valid_o <= w_fire_alu | w_mul_done;

            if (w_fire_mul) begin
                r_mul_a   <= bus.rd1;
                r_mul_b   <= w_opb;
                r_mul_rd2 <= bus.rd2;
                r_mul_fw  <= bus.FlagWrite;
                r_mul_rw  <= bus.RegWrite;
                r_mul_m2r <= bus.MemtoReg;
                r_mul_mw  <= bus.MemWrite;
                r_mul_br  <= bus.Branch;
                r_mul_pcs <= bus.PCSrc;
                r_mul_wa3 <= bus.WA3;
            end

            if (r_state == MUL0) begin
                r_mul_res0 <= w_mul_sat;
                r_mul_v0   <= w_mul_ovf;
            end
            if (r_state == MUL1) begin
                r_mul_res1 <= w_mul_sat;
            end

            if (w_fire_alu) begin
                r_result <= w_lane_res;
                r_wdata  <= bus.rd2;
                r_rw     <= bus.RegWrite;
                r_m2r    <= bus.MemtoReg;
                r_mw     <= bus.MemWrite;
                r_br     <= bus.Branch;
                r_pcs    <= bus.PCSrc;
                r_wa3    <= bus.WA3;
                if (bus.FlagWrite) r_flags <= w_lane_flags[0];
            end

            // Lane 2 comes straight off the multiplier on the final edge.
            if (w_mul_done) begin
                r_result <= {w_mul_sat, r_mul_res1, r_mul_res0};
                r_wdata  <= r_mul_rd2;
                r_rw     <= r_mul_rw;
                r_m2r    <= r_mul_m2r;
                r_mw     <= r_mul_mw;
                r_br     <= r_mul_br;
                r_pcs    <= r_mul_pcs;
                r_wa3    <= r_mul_wa3;
                if (r_mul_fw) r_flags <= w_mul_flags;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.stall      = (r_state != IDLE);
    assign bus.valid_o    = r_valid_o;
    assign bus.alu_result = r_result;
    assign bus.write_data = r_wdata;
    assign bus.flags      = r_flags;
    assign bus.RegWriteO  = r_rw;
    assign bus.MemtoRegO  = r_m2r;
    assign bus.MemWriteO  = r_mw;
    assign bus.BranchO    = r_br;
    assign bus.PCSrcO     = r_pcs;
    assign bus.WA3O       = r_wa3;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vector_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_vector_execute_stage
// Directed bench for vector_execute_stage with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_vector_execute_stage;
    import gpu_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     errors;
    int     checks;

    vector_execute_stage_if bus ();

    vector_execute_stage dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock/reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [53:0] l3(input int v0, input int v1, input int v2);
        return {18'(v2), 18'(v1), 18'(v0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op,
                         input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2,
                         input logic alusrc, input logic fw, input logic [3:0] wa);
        bus.valid_i    = 1'b1;
        bus.ALUControl = op;
        bus.ALUSrc     = alusrc;
        bus.FlagWrite  = fw;
        bus.rd1        = l3(a0, a1, a2);
        if (alusrc) begin
            bus.extend = l3(b0, b1, b2);
            bus.rd2    = l3(77, 88, 99);
        end else begin
            bus.rd2    = l3(b0, b1, b2);
            bus.extend = l3(66, 55, 44);
        end
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b0;
        bus.MemWrite = wa[0];
        bus.Branch   = 1'b0;
        bus.PCSrc    = wa[1];
        bus.WA3      = wa;
    endtask

    task automatic idle_inputs();
        bus.valid_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.valid_i = 1'b0; bus.rd1 = '0; bus.rd2 = '0; bus.extend = '0;
        bus.ALUSrc = 1'b0; bus.ALUControl = '0; bus.FlagWrite = 1'b0;
        bus.RegWrite = 1'b0; bus.MemtoReg = 1'b0; bus.MemWrite = 1'b0;
        bus.Branch = 1'b0; bus.PCSrc = 1'b0; bus.WA3 = '0; bus.flush = 1'b0;

        step();
        step();
        check("rst_valid",  64'(bus.valid_o), 64'd0);
        check("rst_stall",  64'(bus.stall), 64'd0);
        check("rst_result", 64'(bus.alu_result), 64'd0);
        check("rst_flags",  64'(bus.flags), 64'd0);
        check("rst_wa3",    64'(bus.WA3O), 64'd0);
        check("rst_state",  64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;

        // ADD with wrap on lane 2
        drive(4'd0, 5, -3, 131071, 7, 3, 1, 1'b0, 1'b1, 4'd5);
        step();
        check("add_valid",  64'(bus.valid_o), 64'd1);
        check("add_result", 64'(bus.alu_result), 64'(l3(12, 0, -131072)));
        check("add_flags",  64'(bus.flags), 64'h0);
        check("add_wdata",  64'(bus.write_data), 64'(l3(7, 3, 1)));
        check("add_wa3",    64'(bus.WA3O), 64'd5);
        check("add_ctrl",   64'({bus.RegWriteO, bus.MemWriteO, bus.PCSrcO}), 64'b110);

        // ADDS saturates lane 2
        drive(4'd8, 5, -3, 131071, 7, 3, 1, 1'b0, 1'b1, 4'd2);
        step();
        check("adds_valid",  64'(bus.valid_o), 64'd1);
        check("adds_result", 64'(bus.alu_result), 64'(l3(12, 0, 131071)));
        check("adds_flags",  64'(bus.flags), 64'h0);

        // idle cycle: valid drops, data holds
        idle_inputs();
        step();
        check("idle_valid",  64'(bus.valid_o), 64'd0);
        check("idle_result", 64'(bus.alu_result), 64'(l3(12, 0, 131071)));

        // MUL with saturation on lane 2; stall for exactly three cycles
        drive(4'd7, 512, -256, 131071, 384, 256, 131071, 1'b0, 1'b1, 4'd9);
        step();
        check("mul_e0_stall", 64'(bus.stall), 64'd1);
        check("mul_e0_valid", 64'(bus.valid_o), 64'd0);
        check("mul_e0_state", 64'(dbg_state), 64'(MUL0));
        step();
        check("mul_e1_stall", 64'(bus.stall), 64'd1);
        check("mul_e1_valid", 64'(bus.valid_o), 64'd0);
        step();
        check("mul_e2_stall", 64'(bus.stall), 64'd1);
        check("mul_e2_valid", 64'(bus.valid_o), 64'd0);
        step();
        check("mul_e3_stall",  64'(bus.stall), 64'd0);
        check("mul_e3_valid",  64'(bus.valid_o), 64'd1);
        check("mul_result",    64'(bus.alu_result), 64'(l3(768, -256, 131071)));
        check("mul_wdata",     64'(bus.write_data), 64'(l3(384, 256, 131071)));
        check("mul_wa3",       64'(bus.WA3O), 64'd9);
        check("mul_flags",     64'(bus.flags), 64'h0);
        idle_inputs();
        step();
        check("mul_after_valid", 64'(bus.valid_o), 64'd0);

        // MUL killed by flush in MUL1, then SUB
        drive(4'd7, 100, 200, 300, 256, 256, 256, 1'b0, 1'b1, 4'd3);
        step();
        check("fl_state0", 64'(dbg_state), 64'(MUL0));
        step();
        check("fl_state1", 64'(dbg_state), 64'(MUL1));
        bus.flush = 1'b1;
        step();
        check("fl_state", 64'(dbg_state), 64'(IDLE));
        check("fl_stall", 64'(bus.stall), 64'd0);
        check("fl_valid", 64'(bus.valid_o), 64'd0);
        check("fl_flags", 64'(bus.flags), 64'h0);
        bus.flush = 1'b0;
        drive(4'd1, 1, 10, -5, 2, 3, -5, 1'b0, 1'b1, 4'd4);
        step();
        check("sub_valid",  64'(bus.valid_o), 64'd1);
        check("sub_result", 64'(bus.alu_result), 64'(l3(-1, 7, 0)));
        check("sub_flags",  64'(bus.flags), 64'h8);
        check("sub_wa3",    64'(bus.WA3O), 64'd4);

        // SHL via immediate, amount 18 clears lane 0; flags held
        drive(4'd5, 1, -1, 3, 18, 17, 1, 1'b1, 1'b0, 4'd1);
        step();
        check("shl_result", 64'(bus.alu_result), 64'(l3(0, -131072, 6)));
        check("shl_wdata",  64'(bus.write_data), 64'(l3(77, 88, 99)));
        check("shl_flags",  64'(bus.flags), 64'h8);

        // SHR logical, amount 20 clears lane 2
        drive(4'd6, -1, 8, 5, 17, 3, 20, 1'b0, 1'b0, 4'd1);
        step();
        check("shr_result", 64'(bus.alu_result), 64'(l3(1, 1, 0)));

        // AVG at N+1 bits
        drive(4'd11, 131071, -3, -131072, 131071, 0, -131072, 1'b0, 1'b0, 4'd1);
        step();
        check("avg_result", 64'(bus.alu_result), 64'(l3(131071, -2, -131072)));
        check("avg_flags",  64'(bus.flags), 64'h8);

        // SUBS saturating both directions
        drive(4'd9, -131072, 5, 131071, 1, 10, -1, 1'b0, 1'b1, 4'd1);
        step();
        check("subs_result", 64'(bus.alu_result), 64'(l3(-131072, -5, 131071)));
        check("subs_flags",  64'(bus.flags), 64'hB);

        // unused opcode gives zero
        drive(4'd13, 5, 5, 5, 1, 1, 1, 1'b0, 1'b1, 4'd1);
        step();
        check("op13_result", 64'(bus.alu_result), 64'd0);
        check("op13_flags",  64'(bus.flags), 64'h4);

        // back-to-back ADD, MUL, ADD with valid_i held high
        drive(4'd0, 1, 2, 3, 10, 20, 30, 1'b0, 1'b0, 4'd6);
        step();
        check("b2b_v0", 64'(bus.valid_o), 64'd1);
        check("b2b_r0", 64'(bus.alu_result), 64'(l3(11, 22, 33)));
        drive(4'd7, 256, -512, 1000, 256, 256, -256, 1'b0, 1'b0, 4'd7);
        step();
        check("b2b_v1", 64'(bus.valid_o), 64'd0);
        step();
        check("b2b_v2", 64'(bus.valid_o), 64'd0);
        step();
        check("b2b_v3", 64'(bus.valid_o), 64'd0);
        step();
        check("b2b_v4", 64'(bus.valid_o), 64'd1);
        check("b2b_r4", 64'(bus.alu_result), 64'(l3(256, -512, -1000)));
        check("b2b_w4", 64'(bus.WA3O), 64'd7);
        check("b2b_s4", 64'(bus.stall), 64'd0);
        drive(4'd0, -1, -2, -3, 1, 2, 3, 1'b0, 1'b1, 4'd8);
        step();
        check("b2b_v5", 64'(bus.valid_o), 64'd1);
        check("b2b_r5", 64'(bus.alu_result), 64'd0);
        check("b2b_f5", 64'(bus.flags), 64'h6);
        check("b2b_w5", 64'(bus.WA3O), 64'd8);

        // async reset in MUL1 aborts; nothing stale afterwards
        drive(4'd7, 512, 512, 512, 512, 512, 512, 1'b0, 1'b1, 4'd2);
        step();
        step();
        check("ar_state_pre", 64'(dbg_state), 64'(MUL1));
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_state",  64'(dbg_state), 64'(IDLE));
        check("ar_stall",  64'(bus.stall), 64'd0);
        check("ar_valid",  64'(bus.valid_o), 64'd0);
        check("ar_result", 64'(bus.alu_result), 64'd0);
        check("ar_flags",  64'(bus.flags), 64'd0);
        check("ar_wa3",    64'(bus.WA3O), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ar_post_valid", 64'(bus.valid_o), 64'd0);
        end
        check("ar_post_result", 64'(bus.alu_result), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
